pipe_controller: RTL and testbench
==================================

Name: pipe_controller

Overview:
- Five-stage-pipeline successor to the single-cycle decoder.
- Decodes the D-stage instruction and carries control through internal E/M/W control registers.
- Generates stall from Tuse/Tnew hazard analysis and tracks a multi-cycle mult/div unit with a busy counter.
- Sits beside the datapath: the datapath freezes PC and the IF/ID register on `stall`; this block inserts the E-stage bubble itself.

Parameters:
- `REG_W`, 5, register index width.
- `MULT_LAT`, 5, cycles mult occupies HI/LO after leaving E.
- `DIV_LAT`, 10, cycles div occupies HI/LO after leaving E.
- `CNT_W`, 4, busy counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- `clk` in 1: clock
- `reset` in 1: reset
- `instr_d` in 32: instruction in D stage
- `stall` out 1: freeze PC/IF-ID, bubble into E
- `d_ext_op` out 2: 00 zero-ext, 01 lui shift, 10 sign-ext
- `d_branch` out 3: 000 none, 001 beq
- `d_jump` out 3: 000 none, 001 j, 010 jal, 011 jr
- `e_alu_op` out 4: 0 add, 1 sub, 2 or, 3 lui-pass
- `e_alu_src` out 1: 1 selects immediate
- `e_md_op` out 2: 00 none, 01 mult, 10 div
- `e_dst` out REG_W: E-stage destination, 0 = none
- `m_dst` out REG_W: M-stage destination
- `m_mem_write` out 1: sw in M
- `md_busy` out 1: HI/LO unit busy
- `w_reg_write` out 1: GRF write enable
- `w_wd_sel` out 2: 00 ALU, 01 mem, 10 PC+8, 11 HI/LO
- `w_dst` out REG_W: GRF write address

Behaviour:
- Clocking and reset: one clock `clk`, rising edge. Reset `reset` is asynchronous, active-high.
- On reset, all E/M/W control registers clear to nop. Every registered output is 0, the busy counter is 0, `md_busy`=0.
- Supported instructions: addu, subu, ori, lw, sw, lui, beq, j, jal, jr, mult, div, mfhi, mflo. Any other encoding decodes as nop: no write, no stall source.
- Destination field:
  - addu, subu, mfhi, mflo use rd.
  - ori, lw, lui use rt.
  - jal uses 31.
  - All others use 0.
  - A destination of 0 is never a hazard.
- Tuse (D):
  - beq rs/rt = 0; jr rs = 0.
  - addu/subu rs,rt = 1; ori/lw/sw rs = 1; mult/div rs,rt = 1.
  - sw rt = 2.
  - Unused operand = infinity.
- Tnew on entry to E: addu/subu/ori/lui/mfhi/mflo = 1; lw = 2; jal = 0.
- Tnew_M = max(Tnew_E − 1, 0), held in the M register.
- Stall when, for source rs or rt (nonzero) with Tuse t, either holds:
  - it equals e_dst and Tnew_E > t, or
  - it equals m_dst and Tnew_M > t.
- MD stall: the D instruction is mult, div, mfhi or mflo AND (md_busy OR e_md_op != 0).
- `stall` = hazard stall OR MD stall. It is combinational, same cycle as instr_d.
- Pipeline advance each edge:
  - E ← decoded D, or all-zero bubble if stall.
  - M ← E.
  - W ← M.
- Busy counter, on each edge:
  - if e_md_op=01, load MULT_LAT;
  - else if e_md_op=10, load DIV_LAT;
  - else if count != 0, decrement.
  - A load has priority over decrement. A new mult/div cannot be in E while busy, because the MD stall prevents it.
- `md_busy` = (count != 0).
- Reset mid-operation drops md_busy to 0 immediately and flushes all stages.
- Branches and jumps resolve in D with a delay slot. There is no flush output.

Decomposition:
- Shared package `ctrl_pkg`:
  - opcode/funct constants;
  - ALU op, ext op, jump, branch, wd_sel encodings;
  - Tnew/Tuse widths;
  - the INF Tuse constant (3).
- Sub-module `instr_decode`: a purely combinational D-stage decode producing the control bundle, dst, Tuse_rs, Tuse_rt, Tnew. It is instantiated once on instr_d.

Test Plan:
- Load-use: lw $8,0($0) (0x8C080000) then addu $9,$8,$8 (0x01084821) → stall=1 for exactly 1 cycle, then addu enters E with e_dst=9.
- Branch after load: lw $8 then beq $8,$8,0 (0x11080000) → stall high 2 cycles. ALU-to-branch: addu $9 then beq $9,$9 → stall 1 cycle.
- Store data: addu $9 then sw $9,0($0) (0xAC090000) → no stall; sw Tuse rt=2, and m_mem_write=1 two cycles after sw leaves D.
- MD: mult $8,$9 (0x01090018) then mflo $10 (0x00005012) → stall for 1 + MULT_LAT = 6 cycles. md_busy high 5 cycles; w_wd_sel=11 and w_dst=10 when mflo reaches W.
- Zero register and jal: ori $0,$0,1 (0x34000001) then addu $9,$0,$0 → no stall. jal (0x0C000000) then jr $31 (0x03E00008) → no stall; w_dst=31, w_wd_sel=10.
- Async reset: assert reset 3 cycles into a div → md_busy, stall and all registered outputs go 0 before the next clk edge; after release, a mflo in D does not stall.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the five-stage pipeline controller.
//   Opcode/funct constants, the control-field encodings that leave the
//   controller (ext, branch, jump, ALU, mult/div, write-data select), the
//   Tuse/Tnew value type and the "never used" Tuse value.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;

  typedef enum logic [1:0] {EXT_ZERO = 2'b00, EXT_LUI = 2'b01, EXT_SIGN = 2'b10} ext_op_e;
  typedef enum logic [2:0] {BR_NONE = 3'b000, BR_BEQ = 3'b001} branch_e;
  typedef enum logic [2:0] {JMP_NONE = 3'b000, JMP_J = 3'b001, JMP_JAL = 3'b010,
                            JMP_JR = 3'b011} jump_e;
  typedef enum logic [3:0] {ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_OR = 4'd2,
                            ALU_LUI = 4'd3} alu_op_e;
  typedef enum logic [1:0] {MD_NONE = 2'b00, MD_MULT = 2'b01, MD_DIV = 2'b10} md_op_e;
  typedef enum logic [1:0] {WD_ALU = 2'b00, WD_MEM = 2'b01, WD_PC8 = 2'b10,
                            WD_HILO = 2'b11} wd_sel_e;

  // Tuse/Tnew values fit in 2 bits; Tuse 3 means the operand is never read,
  // which is larger than any Tnew and therefore never stalls.
  localparam int T_W = 2;
  typedef logic [T_W-1:0] tval_t;
  localparam tval_t TUSE_INF = 2'd3;

  typedef struct packed {
    ext_op_e ext_op;
    branch_e branch;
    jump_e   jump;
    alu_op_e alu_op;
    logic    alu_src;
    md_op_e  md_op;
    logic    mem_write;
    logic    reg_write;
    wd_sel_e wd_sel;
  } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational D-stage decoder.
//   instr    : 32-bit instruction in D
//   ctl      : control bundle for D/E/M/W
//   dst      : destination register (0 = none)
//   rs, rt   : source register fields
//   tuse_rs/tuse_rt : cycles until the operand is needed (TUSE_INF = unused)
//   tnew     : cycles, on entry to E, until the result is available
//   is_md    : instruction uses the HI/LO unit (mult, div, mfhi, mflo)
module instr_decode
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [31:0]      instr,
  output ctrl_t            ctl,
  output logic [REG_W-1:0] dst,
  output logic [REG_W-1:0] rs,
  output logic [REG_W-1:0] rt,
  output tval_t            tuse_rs,
  output tval_t            tuse_rt,
  output tval_t            tnew,
  output logic             is_md
);

  logic [5:0]       op;
  logic [5:0]       fn;
  logic [4:0]       shamt;
  logic [REG_W-1:0] rd;

  assign op    = instr[31:26];
  assign fn    = instr[5:0];
  assign shamt = instr[10:6];
  assign rs    = REG_W'(instr[25:21]);
  assign rt    = REG_W'(instr[20:16]);
  assign rd    = REG_W'(instr[15:11]);

  always_comb begin
    ctl     = '0;
    dst     = '0;
    tuse_rs = TUSE_INF;
    tuse_rt = TUSE_INF;
    tnew    = '0;
    is_md   = 1'b0;
    case (op)
      // R-type is only recognised with a zero shamt field; anything else is a nop.
      OP_RTYPE: if (shamt == 5'd0) begin
        case (fn)
          FN_ADDU, FN_SUBU: begin
            ctl.alu_op    = (fn == FN_SUBU) ? ALU_SUB : ALU_ADD;
            ctl.reg_write = 1'b1;
            dst     = rd;
            tuse_rs = 2'd1;
            tuse_rt = 2'd1;
            tnew    = 2'd1;
          end
          FN_JR: begin
            ctl.jump = JMP_JR;
            tuse_rs  = 2'd0;
          end
          FN_MULT, FN_DIV: begin
            ctl.md_op = (fn == FN_DIV) ? MD_DIV : MD_MULT;
            tuse_rs = 2'd1;
            tuse_rt = 2'd1;
            is_md   = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            ctl.reg_write = 1'b1;
            ctl.wd_sel    = WD_HILO;
            dst   = rd;
            tnew  = 2'd1;
            is_md = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        ctl.ext_op    = EXT_ZERO;
        ctl.alu_op    = ALU_OR;
        ctl.alu_src   = 1'b1;
        ctl.reg_write = 1'b1;
        dst     = rt;
        tuse_rs = 2'd1;
        tnew    = 2'd1;
      end
      OP_LW: begin
        ctl.ext_op    = EXT_SIGN;
        ctl.alu_src   = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.wd_sel    = WD_MEM;
        dst     = rt;
        tuse_rs = 2'd1;
        tnew    = 2'd2;
      end
      OP_SW: begin
        ctl.ext_op    = EXT_SIGN;
        ctl.alu_src   = 1'b1;
        ctl.mem_write = 1'b1;
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      OP_LUI: begin
        ctl.ext_op    = EXT_LUI;
        ctl.alu_op    = ALU_LUI;
        ctl.alu_src   = 1'b1;
        ctl.reg_write = 1'b1;
        dst  = rt;
        tnew = 2'd1;
      end
      OP_BEQ: begin
        ctl.branch = BR_BEQ;
        ctl.ext_op = EXT_SIGN;
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      OP_J:  ctl.jump = JMP_J;
      OP_JAL: begin
        ctl.jump      = JMP_JAL;
        ctl.reg_write = 1'b1;
        ctl.wd_sel    = WD_PC8;
        dst  = REG_W'(31);
        tnew = 2'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// pipe_controller: control path of the five-stage pipeline.
//   clk, reset   : clock, asynchronous active-high reset
//   instr_d      : instruction in D
//   stall        : freeze PC and IF/ID; E receives a bubble
//   d_*          : D-stage decode (ext op, branch, jump)
//   e_*          : E-stage control (ALU op/src, mult/div op, destination)
//   m_*          : M-stage control (destination, store enable)
//   md_busy      : HI/LO unit still computing
//   w_*          : W-stage GRF write enable, data select, address
module pipe_controller
  import ctrl_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_d,
  output logic             stall,
  output logic [1:0]       d_ext_op,
  output logic [2:0]       d_branch,
  output logic [2:0]       d_jump,
  output logic [3:0]       e_alu_op,
  output logic             e_alu_src,
  output logic [1:0]       e_md_op,
  output logic [REG_W-1:0] e_dst,
  output logic [REG_W-1:0] m_dst,
  output logic             m_mem_write,
  output logic             md_busy,
  output logic             w_reg_write,
  output logic [1:0]       w_wd_sel,
  output logic [REG_W-1:0] w_dst
);

  ctrl_t            d_ctl;
  logic [REG_W-1:0] d_dst, d_rs, d_rt;
  tval_t            d_tuse_rs, d_tuse_rt, d_tnew;
  logic             d_is_md;

  instr_decode #(.REG_W(REG_W)) u_decode (
    .instr   (instr_d),
    .ctl     (d_ctl),
    .dst     (d_dst),
    .rs      (d_rs),
    .rt      (d_rt),
    .tuse_rs (d_tuse_rs),
    .tuse_rt (d_tuse_rt),
    .tnew    (d_tnew),
    .is_md   (d_is_md)
  );

  alu_op_e          e_alu_op_p0;
  logic             e_alu_src_p0;
  md_op_e           e_md_op_p0;
  logic             e_mem_write_p0;
  logic             e_reg_write_p0;
  wd_sel_e          e_wd_sel_p0;
  logic [REG_W-1:0] e_dst_p0;
  tval_t            e_tnew_p0;

  logic [REG_W-1:0] m_dst_p1;
  tval_t            m_tnew_p1;
  logic             m_mem_write_p1;
  logic             m_reg_write_p1;
  wd_sel_e          m_wd_sel_p1;

  logic             w_reg_write_p2;
  wd_sel_e          w_wd_sel_p2;
  logic [REG_W-1:0] w_dst_p2;

  logic [CNT_W-1:0] md_cnt;
  tval_t            e_tnew_next;
  logic             hazard_stall, md_stall;

  // A source stalls when a producer in E or M will not have its result
  // ready by the time D's instruction needs it. Register 0 never stalls.
  function automatic logic src_hazard(input logic [REG_W-1:0] src, input tval_t tuse);
    return (src != '0) &&
           (((src == e_dst_p0) && (e_tnew_p0 > tuse)) ||
            ((src == m_dst_p1) && (m_tnew_p1 > tuse)));
  endfunction

  assign hazard_stall = src_hazard(d_rs, d_tuse_rs) || src_hazard(d_rt, d_tuse_rt);
  assign md_busy      = (md_cnt != '0);
  assign md_stall     = d_is_md && (md_busy || (e_md_op_p0 != MD_NONE));
  assign stall        = hazard_stall || md_stall;
  assign e_tnew_next  = (e_tnew_p0 != '0) ? (e_tnew_p0 - tval_t'(1)) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_alu_op_p0    <= ALU_ADD;
      e_alu_src_p0   <= 1'b0;
      e_md_op_p0     <= MD_NONE;
      e_mem_write_p0 <= 1'b0;
      e_reg_write_p0 <= 1'b0;
      e_wd_sel_p0    <= WD_ALU;
      e_dst_p0       <= '0;
      e_tnew_p0      <= '0;
      m_dst_p1       <= '0;
      m_tnew_p1      <= '0;
      m_mem_write_p1 <= 1'b0;
      m_reg_write_p1 <= 1'b0;
      m_wd_sel_p1    <= WD_ALU;
      w_reg_write_p2 <= 1'b0;
      w_wd_sel_p2    <= WD_ALU;
      w_dst_p2       <= '0;
      md_cnt         <= '0;
    end else begin
      // D -> E: a stall turns the E slot into an all-zero bubble
      if (stall) begin
        e_alu_op_p0    <= ALU_ADD;
        e_alu_src_p0   <= 1'b0;
        e_md_op_p0     <= MD_NONE;
        e_mem_write_p0 <= 1'b0;
        e_reg_write_p0 <= 1'b0;
        e_wd_sel_p0    <= WD_ALU;
        e_dst_p0       <= '0;
        e_tnew_p0      <= '0;
      end else begin
        e_alu_op_p0    <= d_ctl.alu_op;
        e_alu_src_p0   <= d_ctl.alu_src;
        e_md_op_p0     <= d_ctl.md_op;
        e_mem_write_p0 <= d_ctl.mem_write;
        e_reg_write_p0 <= d_ctl.reg_write;
        e_wd_sel_p0    <= d_ctl.wd_sel;
        e_dst_p0       <= d_dst;
        e_tnew_p0      <= d_tnew;
      end
      // E -> M
      m_dst_p1       <= e_dst_p0;
      m_tnew_p1      <= e_tnew_next;
      m_mem_write_p1 <= e_mem_write_p0;
      m_reg_write_p1 <= e_reg_write_p0;
      m_wd_sel_p1    <= e_wd_sel_p0;
      // M -> W
      w_reg_write_p2 <= m_reg_write_p1;
      w_wd_sel_p2    <= m_wd_sel_p1;
      w_dst_p2       <= m_dst_p1;
      // HI/LO occupancy starts when mult/div leaves E
      if (e_md_op_p0 == MD_MULT)      md_cnt <= CNT_W'(MULT_LAT);
      else if (e_md_op_p0 == MD_DIV)  md_cnt <= CNT_W'(DIV_LAT);
      else if (md_cnt != '0)          md_cnt <= md_cnt - CNT_W'(1);
    end
  end

  assign d_ext_op    = d_ctl.ext_op;
  assign d_branch    = d_ctl.branch;
  assign d_jump      = d_ctl.jump;
  assign e_alu_op    = e_alu_op_p0;
  assign e_alu_src   = e_alu_src_p0;
  assign e_md_op     = e_md_op_p0;
  assign e_dst       = e_dst_p0;
  assign m_dst       = m_dst_p1;
  assign m_mem_write = m_mem_write_p1;
  assign w_reg_write = w_reg_write_p2;
  assign w_wd_sel    = w_wd_sel_p2;
  assign w_dst       = w_dst_p2;

endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: directed-vector bench for pipe_controller.
module tb_pipe_controller;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] LW8     = 32'h8C08_0000;  // lw   $8,0($0)
  localparam logic [31:0] ADDU988 = 32'h0108_4821;  // addu $9,$8,$8
  localparam logic [31:0] ADDU900 = 32'h0000_4821;  // addu $9,$0,$0
  localparam logic [31:0] BEQ88   = 32'h1108_0000;  // beq  $8,$8,0
  localparam logic [31:0] BEQ99   = 32'h1129_0000;  // beq  $9,$9,0
  localparam logic [31:0] SW9     = 32'hAC09_0000;  // sw   $9,0($0)
  localparam logic [31:0] MULT89  = 32'h0109_0018;  // mult $8,$9
  localparam logic [31:0] DIV89   = 32'h0109_001A;  // div  $8,$9
  localparam logic [31:0] MFLO10  = 32'h0000_5012;  // mflo $10
  localparam logic [31:0] ORI0    = 32'h3400_0001;  // ori  $0,$0,1
  localparam logic [31:0] LUI5    = 32'h3C05_1234;  // lui  $5,0x1234
  localparam logic [31:0] JAL0    = 32'h0C00_0000;  // jal  0
  localparam logic [31:0] JR31    = 32'h03E0_0008;  // jr   $31

  logic        clk, reset;
  logic [31:0] instr_d;
  logic        stall, e_alu_src, m_mem_write, md_busy, w_reg_write;
  logic [1:0]  d_ext_op, e_md_op, w_wd_sel;
  logic [2:0]  d_branch, d_jump;
  logic [3:0]  e_alu_op;
  logic [4:0]  e_dst, m_dst, w_dst;

  int checks = 0;
  int errors = 0;
  int n_stall, n_busy;

  pipe_controller dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .stall(stall),
    .d_ext_op(d_ext_op), .d_branch(d_branch), .d_jump(d_jump),
    .e_alu_op(e_alu_op), .e_alu_src(e_alu_src), .e_md_op(e_md_op), .e_dst(e_dst),
    .m_dst(m_dst), .m_mem_write(m_mem_write), .md_busy(md_busy),
    .w_reg_write(w_reg_write), .w_wd_sel(w_wd_sel), .w_dst(w_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    instr_d = NOP;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Holds instr_d and counts consecutive stall cycles (and md_busy cycles among them).
  task automatic count_stall(output int ns, output int nb);
    ns = 0;
    nb = 0;
    #1;
    while (stall === 1'b1 && ns < 30) begin
      ns++;
      if (md_busy === 1'b1) nb++;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    instr_d = NOP;
    reset = 1'b1;
    #12;
    check("rst_stall", stall, 0);
    check("rst_md_busy", md_busy, 0);
    check("rst_e_dst", e_dst, 0);
    check("rst_w_reg_write", w_reg_write, 0);
    check("rst_w_wd_sel", w_wd_sel, 0);
    do_reset();

    // Load-use: one bubble, then addu enters E
    instr_d = LW8; #1;
    check("lw_ext_sign", d_ext_op, 2);
    check("lw_no_stall", stall, 0);
    step();
    instr_d = ADDU988;
    count_stall(n_stall, n_busy);
    check("loaduse_stall_cycles", n_stall, 1);
    step();
    check("loaduse_addu_e_dst", e_dst, 9);
    check("loaduse_addu_alu_op", e_alu_op, 0);

    // Branch after load: two stall cycles
    do_reset();
    instr_d = LW8; step();
    instr_d = BEQ88; #1;
    check("beq_d_branch", d_branch, 1);
    count_stall(n_stall, n_busy);
    check("lw_beq_stall_cycles", n_stall, 2);

    // ALU result to branch: one stall cycle
    do_reset();
    instr_d = ADDU988; step();
    instr_d = BEQ99;
    count_stall(n_stall, n_busy);
    check("addu_beq_stall_cycles", n_stall, 1);

    // Store data needed late: no stall, store enable reaches M
    do_reset();
    instr_d = ADDU988; step();
    instr_d = SW9; #1;
    check("sw_no_stall", stall, 0);
    step();
    instr_d = NOP;
    check("sw_in_e_m_mem_write", m_mem_write, 0);
    step();
    check("sw_in_m_mem_write", m_mem_write, 1);

    // mult then mflo: 1 + MULT_LAT stall cycles, md_busy for MULT_LAT
    do_reset();
    instr_d = MULT89; #1;
    check("mult_no_stall", stall, 0);
    step();
    check("mult_e_md_op", e_md_op, 1);
    instr_d = MFLO10;
    count_stall(n_stall, n_busy);
    check("mflo_stall_cycles", n_stall, 6);
    check("mult_busy_cycles", n_busy, 5);
    check("mult_busy_done", md_busy, 0);
    step();
    instr_d = NOP;
    check("mflo_e_dst", e_dst, 10);
    step();
    step();
    check("mflo_w_wd_sel", w_wd_sel, 3);
    check("mflo_w_dst", w_dst, 10);
    check("mflo_w_reg_write", w_reg_write, 1);

    // Writes to $0 are never a hazard
    do_reset();
    instr_d = ORI0; #1;
    check("ori_ext_zero", d_ext_op, 0);
    step();
    check("ori_e_alu_op", e_alu_op, 2);
    check("ori_e_alu_src", e_alu_src, 1);
    instr_d = ADDU900; #1;
    check("zero_reg_no_stall", stall, 0);

    // lui decode
    do_reset();
    instr_d = LUI5; #1;
    check("lui_ext_op", d_ext_op, 1);
    step();
    instr_d = NOP;
    check("lui_e_alu_op", e_alu_op, 3);
    check("lui_e_dst", e_dst, 5);

    // jal then jr $31: link value forwarded with Tnew 0, no stall
    do_reset();
    instr_d = JAL0; #1;
    check("jal_d_jump", d_jump, 2);
    step();
    instr_d = JR31; #1;
    check("jr_no_stall", stall, 0);
    check("jr_d_jump", d_jump, 3);
    check("jal_e_dst", e_dst, 31);
    step();
    instr_d = NOP;
    step();
    check("jal_w_dst", w_dst, 31);
    check("jal_w_wd_sel", w_wd_sel, 2);
    check("jal_w_reg_write", w_reg_write, 1);

    // Asynchronous reset in the middle of a div
    do_reset();
    instr_d = DIV89; step();
    instr_d = ADDU988; step();
    instr_d = LW8; step();
    instr_d = NOP; step();
    check("div_busy_before_reset", md_busy, 1);
    check("div_w_dst_before_reset", w_dst, 9);
    check("div_m_dst_before_reset", m_dst, 8);
    instr_d = MFLO10; #1;
    check("div_mflo_stall", stall, 1);
    reset = 1'b1; #1;
    check("arst_md_busy", md_busy, 0);
    check("arst_stall", stall, 0);
    check("arst_m_dst", m_dst, 0);
    check("arst_w_dst", w_dst, 0);
    check("arst_w_reg_write", w_reg_write, 0);
    #1;
    reset = 1'b0;
    step();
    check("post_rst_mflo_no_stall", stall, 0);
    check("post_rst_mflo_e_dst", e_dst, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
